// File: rtl/dlfloat_pkg.sv
// Shared DLFloat constants, bus phase encodings and small helpers used by the
// host-link pin protocol blocks.
package dlfloat_pkg;

  localparam int DLF_W      = 16;
  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MAN_W  = 9;
  localparam int DLF_BIAS   = 31;
  localparam int DLF_BYTE_W = 8;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } tx_phase_e;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } rx_phase_e;

  function automatic logic dlf_is_nan(input logic [DLF_W-1:0] value);
    return (value == DLF_NAN);
  endfunction

endpackage

// File: rtl/dlfloat_byte_reasm.sv
// Rebuilds 16-bit results from the MAC's byte-serial output (high byte first),
// drops the pipeline-fill words after reset and holds one result for downstream.
module dlfloat_byte_reasm
  import dlfloat_pkg::*;
#(
  parameter int RX_PHASE = 0,
  parameter int WARMUP   = 3,
  parameter int CNT_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DLF_BYTE_W-1:0] i_pin_byte,
  input  logic                  i_res_ready,
  output logic                  o_res_valid,
  output logic [DLF_W-1:0]      o_res_data,
  output logic                  o_overflow,
  output logic [CNT_W-1:0]      o_results_rcvd
);

  rx_phase_e             r_rx_phase;
  logic [DLF_BYTE_W-1:0] r_hi;
  logic [3:0]            r_warm;
  logic                  r_res_valid;
  logic [DLF_W-1:0]      r_res_data;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_results_rcvd;

  logic w_word_done;
  logic w_warm_busy;
  logic w_drain;
  logic w_load;
  logic w_lose;

  assign w_word_done = (r_rx_phase == PH_LO);
  assign w_warm_busy = (r_warm != 4'd0);
  assign w_drain     = r_res_valid & i_res_ready;
  // A draining slot counts as free, so a back-to-back word never overflows.
  assign w_load      = w_word_done & ~w_warm_busy & (~r_res_valid | i_res_ready);
  assign w_lose      = w_word_done & ~w_warm_busy & r_res_valid & ~i_res_ready;

  // Phase tracking, warm-up discard, result slot and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_phase     <= rx_phase_e'(1'(RX_PHASE));
      r_hi           <= 8'h00;
      r_warm         <= 4'(WARMUP);
      r_res_valid    <= 1'b0;
      r_res_data     <= DLF_ZERO;
      r_overflow     <= 1'b0;
      r_results_rcvd <= {CNT_W{1'b0}};
    end else begin
      r_rx_phase <= rx_phase_e'(~r_rx_phase);
      if (r_rx_phase == PH_HI) begin
        r_hi <= i_pin_byte;
      end
      if (w_word_done && w_warm_busy) begin
        r_warm <= r_warm - 4'd1;
      end
      if (w_drain) begin
        r_results_rcvd <= r_results_rcvd + CNT_W'(1);
      end
      if (w_load) begin
        r_res_data  <= {r_hi, i_pin_byte};
        r_res_valid <= 1'b1;
      end else if (w_drain) begin
        r_res_valid <= 1'b0;
      end
      if (w_lose) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_res_valid    = r_res_valid;
  assign o_res_data     = r_res_data;
  assign o_overflow     = r_overflow;
  assign o_results_rcvd = r_results_rcvd;

endmodule

// File: rtl/dlfloat_mac_host_link.sv
// Host end of the DLFloat MAC pin protocol: operand pairs go out A then B on the
// 16-bit bus, byte-serial results come back as words. DLFLOAT_NAN_FLAG_EN adds NaN tracking.
module dlfloat_mac_host_link
  import dlfloat_pkg::*;
#(
  parameter int RX_PHASE = 0,
  parameter int WARMUP   = 3,
  parameter int CNT_W    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_op_valid,
  input  logic [DLF_W-1:0]      i_op_a,
  input  logic [DLF_W-1:0]      i_op_b,
  output logic                  o_op_ready,
  output logic [DLF_W-1:0]      o_pin_data,
  input  logic [DLF_BYTE_W-1:0] i_pin_byte,
  output logic                  o_res_valid,
  output logic [DLF_W-1:0]      o_res_data,
  input  logic                  i_res_ready,
  output logic                  o_overflow,
  output logic [CNT_W-1:0]      o_pairs_sent,
`ifdef DLFLOAT_NAN_FLAG_EN
  output logic                  o_nan_seen,
  output logic [CNT_W-1:0]      o_nan_first,
`endif
  output logic [CNT_W-1:0]      o_results_rcvd
);

  tx_phase_e        r_tx_phase;
  logic [DLF_W-1:0] r_a;
  logic [DLF_W-1:0] r_b;
  logic [CNT_W-1:0] r_pairs_sent;

  logic             w_accept;
  logic             w_res_valid;
  logic [DLF_W-1:0] w_res_data;
  logic [CNT_W-1:0] w_results_rcvd;

  assign o_op_ready = (r_tx_phase == PH_B) & ~i_rst;
  assign o_pin_data = (r_tx_phase == PH_A) ? r_a : r_b;
  assign w_accept   = o_op_ready & i_op_valid;

  // TX phase and operand holding; an empty slot sends a zero pair.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_phase   <= PH_A;
      r_a          <= DLF_ZERO;
      r_b          <= DLF_ZERO;
      r_pairs_sent <= {CNT_W{1'b0}};
    end else begin
      r_tx_phase <= tx_phase_e'(~r_tx_phase);
      if (r_tx_phase == PH_B) begin
        if (i_op_valid) begin
          r_a          <= i_op_a;
          r_b          <= i_op_b;
          r_pairs_sent <= r_pairs_sent + CNT_W'(1);
        end else begin
          r_a <= DLF_ZERO;
          r_b <= DLF_ZERO;
        end
      end
    end
  end

  dlfloat_byte_reasm #(
    .RX_PHASE (RX_PHASE),
    .WARMUP   (WARMUP),
    .CNT_W    (CNT_W)
  ) u_reasm (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pin_byte     (i_pin_byte),
    .i_res_ready    (i_res_ready),
    .o_res_valid    (w_res_valid),
    .o_res_data     (w_res_data),
    .o_overflow     (o_overflow),
    .o_results_rcvd (w_results_rcvd)
  );

`ifdef DLFLOAT_NAN_FLAG_EN
  logic             r_nan_seen;
  logic             r_nan_res_seen;
  logic [CNT_W-1:0] r_nan_first;
  logic             w_nan_res;
  logic             w_nan_op;

  assign w_nan_res = w_res_valid & i_res_ready & dlf_is_nan(w_res_data);
  assign w_nan_op  = w_accept & (dlf_is_nan(i_op_a) | dlf_is_nan(i_op_b));

  // Sticky NaN flag; nan_first latches the delivery index of the first NaN result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nan_seen     <= 1'b0;
      r_nan_res_seen <= 1'b0;
      r_nan_first    <= {CNT_W{1'b0}};
    end else begin
      if (w_nan_res || w_nan_op) begin
        r_nan_seen <= 1'b1;
      end
      if (w_nan_res && !r_nan_res_seen) begin
        r_nan_res_seen <= 1'b1;
        r_nan_first    <= w_results_rcvd;
      end
    end
  end

  assign o_nan_seen  = r_nan_seen;
  assign o_nan_first = r_nan_first;
`endif

  assign o_res_valid    = w_res_valid;
  assign o_res_data     = w_res_data;
  assign o_results_rcvd = w_results_rcvd;
  assign o_pairs_sent   = r_pairs_sent;

endmodule

// File: tb/tb_dlfloat_mac_host_link.sv
// Self-checking bench for dlfloat_mac_host_link: directed table and sequences,
// then randomized traffic against a cycle-count based reference model.
module tb_dlfloat_mac_host_link;

  localparam int RXP  = 0;
  localparam int WARM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  pin_byte;
  logic        res_ready;
  logic        w_op_ready;
  logic [15:0] w_pin_data;
  logic        w_res_valid;
  logic [15:0] w_res_data;
  logic        w_overflow;
  logic [15:0] w_pairs_sent;
  logic [15:0] w_results_rcvd;
`ifdef DLFLOAT_NAN_FLAG_EN
  logic        w_nan_seen;
  logic [15:0] w_nan_first;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dlfloat_mac_host_link #(.RX_PHASE(RXP), .WARMUP(WARM), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_op_valid     (op_valid),
    .i_op_a         (op_a),
    .i_op_b         (op_b),
    .o_op_ready     (w_op_ready),
    .o_pin_data     (w_pin_data),
    .i_pin_byte     (pin_byte),
    .o_res_valid    (w_res_valid),
    .o_res_data     (w_res_data),
    .i_res_ready    (res_ready),
    .o_overflow     (w_overflow),
    .o_pairs_sent   (w_pairs_sent),
`ifdef DLFLOAT_NAN_FLAG_EN
    .o_nan_seen     (w_nan_seen),
    .o_nan_first    (w_nan_first),
`endif
    .o_results_rcvd (w_results_rcvd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    op_a = 16'h0000;
    op_b = 16'h0000;
    pin_byte = 8'h00;
    res_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: cycle count since reset gives both phases; words are counted.
  int          mk;
  int          mwords;
  logic [15:0] ma, mb, mrd, msent, mrcvd;
  logic [7:0]  mhi;
  logic        mrv, movf;

  task automatic model_edge();
    logic drained;
    logic loaded;
    if (rst) begin
      mk = 0; mwords = 0; ma = 16'h0; mb = 16'h0; mrd = 16'h0; msent = 16'h0;
      mrcvd = 16'h0; mhi = 8'h0; mrv = 1'b0; movf = 1'b0;
    end else begin
      drained = mrv && res_ready;
      loaded  = 1'b0;
      if (mk % 2 == 1) begin
        if (op_valid) begin
          ma = op_a; mb = op_b; msent = msent + 16'd1;
        end else begin
          ma = 16'h0; mb = 16'h0;
        end
      end
      if (drained) mrcvd = mrcvd + 16'd1;
      if ((mk + RXP) % 2 == 0) begin
        mhi = pin_byte;
      end else begin
        mwords++;
        if (mwords > WARM) begin
          if (!mrv || res_ready) begin
            mrd = {mhi, pin_byte};
            loaded = 1'b1;
          end else begin
            movf = 1'b1;
          end
        end
      end
      if (loaded) mrv = 1'b1;
      else if (drained) mrv = 1'b0;
      mk++;
    end
  endtask

  task automatic check_model();
    chk("rnd_op_ready", {31'd0, w_op_ready}, {31'd0, (mk % 2 == 1) && !rst});
    chk("rnd_pin_data", {16'd0, w_pin_data}, {16'd0, (mk % 2 == 0) ? ma : mb});
    chk("rnd_res_valid", {31'd0, w_res_valid}, {31'd0, mrv});
    chk("rnd_res_data", {16'd0, w_res_data}, {16'd0, mrd});
    chk("rnd_overflow", {31'd0, w_overflow}, {31'd0, movf});
    chk("rnd_pairs_sent", {16'd0, w_pairs_sent}, {16'd0, msent});
    chk("rnd_results_rcvd", {16'd0, w_results_rcvd}, {16'd0, mrcvd});
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        rdy;
    logic        v;
    logic [15:0] d;
    logic        ovf;
    logic [15:0] rc;
  } rx_vec_t;

  rx_vec_t tbl [13];

  initial begin
    tbl[0]  = '{8'h11, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[1]  = '{8'h22, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[2]  = '{8'h33, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[3]  = '{8'h44, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[4]  = '{8'h55, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[5]  = '{8'h66, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[6]  = '{8'h77, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    tbl[7]  = '{8'h88, 1'b1, 1'b1, 16'h7788, 1'b0, 16'd0};
    tbl[8]  = '{8'h99, 1'b0, 1'b1, 16'h7788, 1'b0, 16'd0};
    tbl[9]  = '{8'hAA, 1'b0, 1'b1, 16'h7788, 1'b1, 16'd0};
    tbl[10] = '{8'hBB, 1'b1, 1'b0, 16'h7788, 1'b1, 16'd1};
    tbl[11] = '{8'hCC, 1'b1, 1'b1, 16'hBBCC, 1'b1, 16'd1};
    tbl[12] = '{8'hDD, 1'b1, 1'b0, 16'hBBCC, 1'b1, 16'd2};

    do_reset();
    chk("rst_op_ready", {31'd0, w_op_ready}, 32'd0);
    chk("rst_pin_data", {16'd0, w_pin_data}, 32'd0);
    chk("rst_res_valid", {31'd0, w_res_valid}, 32'd0);
    chk("rst_res_data", {16'd0, w_res_data}, 32'd0);
    chk("rst_overflow", {31'd0, w_overflow}, 32'd0);
    chk("rst_pairs_sent", {16'd0, w_pairs_sent}, 32'd0);
    chk("rst_results_rcvd", {16'd0, w_results_rcvd}, 32'd0);
`ifdef DLFLOAT_NAN_FLAG_EN
    chk("rst_nan_seen", {31'd0, w_nan_seen}, 32'd0);
    chk("rst_nan_first", {16'd0, w_nan_first}, 32'd0);
`endif

    // Held operand pair: ready on odd cycles, pin_data carries it from cycle 2.
    op_valid = 1'b1;
    op_a = 16'h3E00;
    op_b = 16'h3E00;
    for (int c = 0; c < 6; c++) begin
      chk("tx_op_ready", {31'd0, w_op_ready}, {31'd0, (c % 2 == 1)});
      chk("tx_pin_data", {16'd0, w_pin_data}, (c < 2) ? 32'h0 : 32'h3E00);
      tick();
      chk("tx_pairs_sent", {16'd0, w_pairs_sent}, (c + 1) / 2);
    end

    do_reset();
    for (int c = 0; c < 10; c++) begin
      chk("idle_pin_data", {16'd0, w_pin_data}, 32'h0);
      tick();
      chk("idle_pairs_sent", {16'd0, w_pairs_sent}, 32'h0);
    end

    do_reset();
    for (int i = 0; i < 13; i++) begin
      pin_byte  = tbl[i].b;
      res_ready = tbl[i].rdy;
      tick();
      chk("tbl_res_valid", {31'd0, w_res_valid}, {31'd0, tbl[i].v});
      chk("tbl_res_data", {16'd0, w_res_data}, {16'd0, tbl[i].d});
      chk("tbl_overflow", {31'd0, w_overflow}, {31'd0, tbl[i].ovf});
      chk("tbl_results_rcvd", {16'd0, w_results_rcvd}, {16'd0, tbl[i].rc});
    end

    // Drain and load in the same cycle: slot stays full, no overflow.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pin_byte = 8'(8'h11 * (i + 1));
      tick();
    end
    chk("sim_first_valid", {31'd0, w_res_valid}, 32'd1);
    chk("sim_first_data", {16'd0, w_res_data}, 32'h7788);
    pin_byte = 8'h01;
    tick();
    pin_byte = 8'h02;
    res_ready = 1'b1;
    tick();
    chk("sim_res_valid", {31'd0, w_res_valid}, 32'd1);
    chk("sim_res_data", {16'd0, w_res_data}, 32'h0102);
    chk("sim_overflow", {31'd0, w_overflow}, 32'd0);
    chk("sim_results_rcvd", {16'd0, w_results_rcvd}, 32'd1);

    // Randomized traffic, occasional mid-stream reset, against the model.
    rst = 1'b1;
    model_edge();
    tick();
    rst = 1'b0;
    check_model();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      op_valid  = ($urandom_range(0, 2) != 0);
      op_a      = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      op_b      = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
      pin_byte  = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      model_edge();
      tick();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
